// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared defaults and queue types for the fetch stage
package pc_fetch_pkg;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_STEP     = 1;
    localparam int QUEUE_DEPTH  = 2;
    localparam int PTR_W        = $clog2(QUEUE_DEPTH);
    typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] qcount_t;
    typedef logic [PTR_W-1:0] qptr_t;
endpackage

// File: rtl/pc_fetch_queue.sv
// fetch_queue: 2-entry {pc, instr} FIFO with flush, push, pop and count
module fetch_queue
    import pc_fetch_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    output qcount_t            count,
    output logic [WIDTH-1:0]   head_pc,
    output logic [INSTR_W-1:0] head_instr
);
    logic [WIDTH-1:0]   pcs    [QUEUE_DEPTH];
    logic [INSTR_W-1:0] instrs [QUEUE_DEPTH];
    qptr_t              wr_ptr;
    qptr_t              rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcs    <= '{default: '0};
            instrs <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pcs[wr_ptr]    <= push_pc;
                instrs[wr_ptr] <= push_instr;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + qcount_t'(push) - qcount_t'(pop);
        end
    end

    assign head_pc    = pcs[rd_ptr];
    assign head_instr = instrs[rd_ptr];
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, credit-limited instruction fetch and 2-entry decode queue
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               INSTR_W  = DEF_INSTR_W,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(DEF_STEP)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [WIDTH-1:0]   sum_a,
    output logic [WIDTH-1:0]   sum_b,
    input  logic [WIDTH-1:0]   sum_y,
    input  logic               br_valid,
    input  logic [WIDTH-1:0]   br_target,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [WIDTH-1:0]   out_pc,
    input  logic               out_ready
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inflight_q;
    logic             pop;
    logic             issue;
    logic [2:0]       pending;
    qcount_t          count;

    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    // Queued plus in-flight entries after this cycle's pop must leave room for one more response
    assign pending   = 3'(count) + 3'(inflight_q) - 3'(pop);
    assign issue     = rst_n && !br_valid && pending < 3'(QUEUE_DEPTH);
    assign imem_en   = issue;
    assign imem_addr = pc;
    assign sum_a     = pc;
    assign sum_b     = STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else if (br_valid) begin
            pc         <= br_target;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= sum_y;
            end
        end
    end

    fetch_queue #(.WIDTH(WIDTH), .INSTR_W(INSTR_W)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (br_valid),
        .push       (inflight_q && !br_valid),
        .pop        (pop),
        .push_pc    (inflight_pc),
        .push_instr (imem_rdata),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: random and directed stimulus against an in-order stream model of pc_fetch
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [7:0]  sum_a, sum_b, sum_y;
    logic        br_valid = 1'b0;
    logic [7:0]  br_target = '0;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_pc;
    int          k;
    bit          all_hi, all_lo;
    bit          held_v;
    logic [7:0]  held_pc;
    logic [15:0] held_instr;
    int          delivered = 0;
    bit          watch = 0, watch_hit = 0;

    always #5 clk = ~clk;

    assign sum_y = sum_a + sum_b;

    always @(posedge clk)
        if (imem_en) imem_rdata <= 16'h1000 + {8'h00, imem_addr};

    pc_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .sum_a      (sum_a),
        .sum_b      (sum_b),
        .sum_y      (sum_y),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_flush(input logic [7:0] start);
        exp_pc = start;
        k      = 0;
        all_hi = 1;
        all_lo = 1;
        held_v = 0;
    endtask

    task automatic reset_checks();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc",    32'(out_pc),    32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_en",    32'(imem_en),   32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        br_valid  = 1'b0;
        out_ready = 1'b0;
        #1 reset_checks();
        repeat (2) @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_flush(8'h00);
    endtask

    task automatic cyc(input bit rdy, input bit br, input logic [7:0] tgt);
        @(negedge clk);
        out_ready = rdy;
        br_valid  = br;
        br_target = tgt;
        if (watch && rdy && out_valid && out_pc == 8'h05) begin
            br_valid  = 1'b1;
            watch     = 0;
            watch_hit = 1;
        end
        #1;
        check("sum_b", 32'(sum_b), 32'd1);
        check("addr_eq_a", 32'(imem_addr), 32'(sum_a));
        if (br_valid) check("en_on_br", 32'(imem_en), 32'd0);
        if (k < 2) check("valid_early", 32'(out_valid), 32'd0);
        if (k >= 2 && all_hi) check("valid_stream", 32'(out_valid), 32'd1);
        if (k >= 2 && all_lo && !out_ready) begin
            check("stall_en", 32'(imem_en), 32'd0);
            check("stall_head_pc", 32'(out_pc), 32'(exp_pc));
            check("stall_head_instr", 32'(out_instr), 32'(16'h1000 + {8'h00, exp_pc}));
        end
        if (held_v) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_pc", 32'(out_pc), 32'(held_pc));
            check("hold_instr", 32'(out_instr), 32'(held_instr));
        end
        held_v     = out_valid && !out_ready && !br_valid;
        held_pc    = out_pc;
        held_instr = out_instr;
        if (out_valid && out_ready) begin
            check("deliv_pc", 32'(out_pc), 32'(exp_pc));
            check("deliv_instr", 32'(out_instr), 32'(16'h1000 + {8'h00, exp_pc}));
            exp_pc++;
            delivered++;
        end
        all_hi &= out_ready;
        all_lo &= !out_ready;
        @(posedge clk);
        if (br_valid) model_flush(br_target);
        else k++;
    endtask

    initial begin
        int bias;
        #2 reset_checks();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_flush(8'h00);
        repeat (12) cyc(1, 0, 8'h00);

        do_reset();
        repeat (6) cyc(0, 0, 8'h00);
        repeat (8) cyc(1, 0, 8'h00);

        do_reset();
        repeat (3) cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h40);
        repeat (8) cyc(1, 0, 8'h00);

        cyc(1, 1, 8'hFE);
        repeat (8) cyc(1, 0, 8'h00);

        do_reset();
        watch = 1;
        for (int i = 0; i < 20 && watch; i++) cyc(1, 0, 8'h80);
        check("watch_hit", 32'(watch_hit), 32'd1);
        watch = 0;
        repeat (6) cyc(1, 0, 8'h00);

        bias = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) bias = $urandom_range(0, 4);
            if (i % 300 == 150) do_reset();
            cyc($urandom_range(0, 4) < bias + 1 ? 1'b1 : 1'b0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0 ? 8'hFE : 8'($urandom));
        end
        check("delivered_some", 32'(delivered > 200), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the microprocessor. It holds the PC, presents it to the synchronous instruction memory, and sends the PC to the shared `adder` (PC + STEP), taking the sum back as the sequential next PC. Fetched instructions, tagged with their PC, are buffered in a 2-entry queue and handed to decode over a valid/ready handshake. A branch redirect from execute flushes everything in flight.

## Interface
- `WIDTH`, default 8: PC/address width, the same as the adder's `WIDTH`.
- `INSTR_W`, default 16: instruction word width.
- `RESET_PC`, default 0: PC value loaded at reset.
- `STEP`, default 1: PC increment, driven on the adder's `b` input.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `imem_en`, output, 1: fetch request; memory samples `imem_addr` at the edge where this is high.
- `imem_addr`, output, WIDTH: fetch address, always equal to the PC register.
- `imem_rdata`, input, INSTR_W: memory data, valid in the cycle after the request edge.
- `sum_a`, output, WIDTH: adder operand a = PC.
- `sum_b`, output, WIDTH: adder operand b = STEP, constant.
- `sum_y`, input, WIDTH: adder result, used as the sequential next PC.
- `br_valid`, input, 1: redirect request, one-cycle pulse.
- `br_target`, input, WIDTH: redirect PC.
- `out_valid`, output, 1: instruction available to decode.
- `out_instr`, output, INSTR_W: instruction word at the queue head.
- `out_pc`, output, WIDTH: PC of `out_instr`.
- `out_ready`, input, 1: decode accepts; transfer occurs when `out_valid && out_ready`.

## Operation
- State:
  - `pc`: WIDTH bits.
  - `inflight_q` / `inflight_pc`: request issued last edge, and its PC.
  - Queue: 2 entries of {pc, instr}, plus `count` (0..2) and read/write pointers.
- Combinational terms:
  - `pop = out_valid && out_ready`.
  - `issue = !br_valid && (count - pop + inflight_q) < 2` (credit rule: the queue can never overflow).
- Outputs:
  - `imem_en = issue`.
  - `out_valid = (count != 0)`; `out_instr`/`out_pc` come from the queue head.
- When `issue` is high at an edge: `inflight_q <= 1`, `inflight_pc <= pc`, `pc <= sum_y`.
- When `issue` is low at an edge: `inflight_q <= 0`, `pc` holds.
- When `inflight_q` is high at an edge: {`inflight_pc`, `imem_rdata`} is pushed into the queue.
- Redirect (`br_valid` high at an edge), which has priority over all of the above:
  - `pc <= br_target`, `inflight_q <= 0`, `count <= 0`, pointers reset.
  - The arriving `imem_rdata` is discarded.
  - A `pop` in the same cycle still counts as a completed transfer to decode; the flush applies afterwards.
- Arithmetic: the PC wraps modulo 2^WIDTH through the adder; 0xFF + 1 gives 0x00 at WIDTH=8.
- Holding: while `out_valid && !out_ready`, `out_instr`/`out_pc` stay stable and `count` never exceeds 2.
- Push and pop in the same cycle: `count` is unchanged and entry order is preserved.

## Timing
- While `rst_n` is low:
  - `pc = RESET_PC`, `inflight_q = 0`, `count = 0`.
  - `out_valid = 0`; `out_instr` and `out_pc` = 0 (queue storage cleared).
  - `imem_en = 0`, forced during reset.
- First edge after `rst_n` rises: the request for RESET_PC issues.
- Latency:
  - Request edge t → data pushed at edge t+1 → `out_valid` high in cycle t+2.
  - Redirect pulse at edge t → `br_target` request at edge t+1 → `out_valid` for it in cycle t+3.
- Throughput: with `out_ready` held high, one instruction per cycle in steady state.
- Reset asserted mid-operation: immediate return to reset values; the in-flight response is dropped.

## Structure
- Shared package holds:
  - Default `WIDTH`/`INSTR_W`, `RESET_PC`, `STEP`.
  - Queue depth constant (2).
- Sub-module `fetch_queue`: 2-entry synchronous FIFO with flush, push, pop and count.
- The adder is instantiated at the level above and wired through `sum_*`; this block contains no internal `+` on the PC.

## Test plan
All scenarios use WIDTH=8, STEP=1, RESET_PC=0x00, memory holding instr = 0x1000 + addr.
- Reset then `out_ready=1`: `out_valid` first high in cycle 2 after release; PCs 0x00, 0x01, 0x02… with instr 0x1000, 0x1001… one per cycle.
- `out_ready=0` for 5 cycles after start: `count` saturates at 2, `imem_en` goes low, head stays {0x00, 0x1000}. On release, 0x00, 0x01, 0x02 arrive in order with no loss or duplication.
- `br_valid` with `br_target=0x40` while 2 entries are queued and one is in flight: queue empties. Next delivered pair is {0x40, 0x1040}, 3 cycles after the pulse, and 0x41 follows.
- Run from `br_target=0xFE`: delivered PCs are 0xFE, 0xFF, 0x00, 0x01 (wrap).
- `br_valid` in the same cycle as `pop` of head 0x05: decode receives 0x05 exactly once, and 0x06 is never delivered.
- `rst_n` pulsed low mid-stream: `out_valid` drops to 0 asynchronously; stream restarts at 0x00.
